tpu_stream_loader: RTL

Host-side front end that sits directly upstream of the tensor accelerator and its SRAM buffers.
- Accepts load commands and a word stream, and writes the words sequentially into the param, input, weight or bias SRAM.
- Launches the accelerator with a start pulse and mode, waits for its finish, and reports completion to the host.
- Owns the SRAM write ports only while the accelerator is idle. Port arbitration is outside this block.

---
 rtl/tpu_loader_pkg.sv | 33 +++
 rtl/tpu_loader_wr_stage.sv | 48 ++++
 rtl/tpu_stream_loader.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/tpu_loader_pkg.sv
// Shared types and widths for the tensor stream loader.
// Bank and FSM encodings plus a bank-to-chip-select helper.
package tpu_loader_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 17;
  localparam int DEF_LEN_W  = 18;
  localparam int NUM_BANKS  = 4;

  typedef enum logic [1:0] {
    BANK_PARAM,
    BANK_INPUT,
    BANK_WEIGHT,
    BANK_BIAS
  } bank_e;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    RUN,
    DONE
  } state_e;

  function automatic logic [NUM_BANKS-1:0] bank_onehot(
    input bank_e b
  );
    logic [NUM_BANKS-1:0] oh;
    oh    = '0;
    oh[b] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/tpu_loader_wr_stage.sv
// Registered SRAM write stage: an accepted beat becomes
// a chip-select/write strobe one cycle later.
module tpu_loader_wr_stage
  import tpu_loader_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 accept_i,
  input  bank_e                bank_i,
  input  logic [ADDR_W-1:0]    addr_i,
  input  logic [DATA_W-1:0]    data_i,
  output logic [NUM_BANKS-1:0] cs_o,
  output logic                 we_o,
  output logic [ADDR_W-1:0]    addr_o,
  output logic [DATA_W-1:0]    wdata_o
);

  logic [NUM_BANKS-1:0] cs_q;
  logic                 we_q;
  logic [ADDR_W-1:0]    addr_q;
  logic [DATA_W-1:0]    wdata_q;

  // Address/data only move on a beat so idle buses stay quiet.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cs_q    <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      we_q <= accept_i;
      cs_q <= accept_i ? bank_onehot(bank_i) : '0;
      if (accept_i) begin
        addr_q  <= addr_i;
        wdata_q <= data_i;
      end
    end
  end

  assign cs_o    = cs_q;
  assign we_o    = we_q;
  assign addr_o  = addr_q;
  assign wdata_o = wdata_q;

endmodule

// File: rtl/tpu_stream_loader.sv
// Host front end: streams words into accelerator SRAM banks,
// then launches the accelerator and reports completion.
module tpu_stream_loader
  import tpu_loader_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int LEN_W  = DEF_LEN_W
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 cmd_valid_i,
  output logic                 cmd_ready_o,
  input  logic [1:0]           cmd_bank_i,
  input  logic [ADDR_W-1:0]    cmd_base_i,
  input  logic [LEN_W-1:0]     cmd_len_i,
  input  logic                 s_valid_i,
  output logic                 s_ready_o,
  input  logic [DATA_W-1:0]    s_data_i,
  input  logic                 run_i,
  input  logic [3:0]           mode_i,
  output logic [NUM_BANKS-1:0] sram_cs_o,
  output logic                 sram_we_o,
  output logic [ADDR_W-1:0]    sram_addr_o,
  output logic [DATA_W-1:0]    sram_wdata_o,
  output logic                 acc_start_o,
  output logic [3:0]           acc_mode_o,
  input  logic                 acc_finish_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 err_o
);

  state_e            state_q, state_d;
  bank_e             bank_q, bank_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]  rem_q, rem_d;
  logic [3:0]        mode_q, mode_d;
  logic              start_q, start_d;
  logic              err_q, err_d;
  logic              en_q;
  logic              idle;
  logic              beat;

  // en_q keeps cmd_ready_o low while reset is asserted.
  assign idle = (state_q == IDLE) && en_q;
  assign beat = s_valid_i && (state_q == LOAD);

  always_comb begin
    state_d = state_q;
    bank_d  = bank_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    mode_d  = mode_q;
    start_d = 1'b0;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        if (en_q && cmd_valid_i) begin
          bank_d = bank_e'(cmd_bank_i);
          addr_d = cmd_base_i;
          rem_d  = cmd_len_i;
          if (cmd_len_i != '0) begin
            state_d = LOAD;
          end
        end else if (en_q && run_i) begin
          mode_d  = mode_i;
          start_d = 1'b1;
          state_d = RUN;
        end
      end
      LOAD: begin
        if (beat) begin
          addr_d = addr_q + ADDR_W'(1);
          rem_d  = rem_q - LEN_W'(1);
          if (&addr_q && rem_q != LEN_W'(1)) begin
            err_d = 1'b1;
          end
          if (rem_q == LEN_W'(1)) begin
            state_d = IDLE;
          end
        end
      end
      RUN: begin
        // Finish is masked during the start pulse.
        if (acc_finish_i && !start_q) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      bank_q  <= BANK_PARAM;
      addr_q  <= '0;
      rem_q   <= '0;
      mode_q  <= '0;
      start_q <= 1'b0;
      err_q   <= 1'b0;
      en_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      bank_q  <= bank_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      mode_q  <= mode_d;
      start_q <= start_d;
      err_q   <= err_d;
      en_q    <= 1'b1;
    end
  end

  tpu_loader_wr_stage #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_wr (
    .clk      (clk),
    .rstn     (rstn),
    .accept_i (beat),
    .bank_i   (bank_q),
    .addr_i   (addr_q),
    .data_i   (s_data_i),
    .cs_o     (sram_cs_o),
    .we_o     (sram_we_o),
    .addr_o   (sram_addr_o),
    .wdata_o  (sram_wdata_o)
  );

  assign cmd_ready_o = idle;
  assign s_ready_o   = (state_q == LOAD);
  assign acc_start_o = start_q;
  assign acc_mode_o  = mode_q;
  assign busy_o      = (state_q != IDLE);
  assign done_o      = (state_q == DONE);
  assign err_o       = err_q;

endmodule
